ps2_rx_fifo: RTL and testbench
==============================

// Module: ps2_rx_fifo
// PURPOSE
//  Parametrised PS/2 keyboard receiver with glitch filter, frame checking, watchdog and scancode FIFO.
//  Sits between the PS2_clk/PS2_Data pads and the IO bus. The CPU polls ready, reads data_out and pulses rd to pop.
//  Adds over the previous keyboard path: input filtering, odd-parity/stop checks, timeout recovery,
//  multi-entry buffering with overflow and sticky error flags.
// PARAMETERS
//  FIFO_DEPTH   8      scancode entries; power of two, >=2
//  FILTER_LEN   8      consecutive equal samples needed to accept a ps2_clk level change; >=1
//  TIMEOUT      50000  clk cycles without a ps2_clk fall before a partial frame is aborted (1 ms @50 MHz)
// PORTS
//  clk         in   1   system clock
//  rst         in   1   asynchronous, active-high reset
//  ps2_clk     in   1   raw PS/2 clock pad (asynchronous)
//  ps2_data    in   1   raw PS/2 data pad (asynchronous)
//  rd          in   1   pop strobe, one cycle; ignored when ready=0
//  clr_err     in   1   clears overflow, parity_err, frame_err
//  data_out    out  8   FIFO head (show-ahead); valid while ready=1
//  ready       out  1   FIFO not empty
//  count       out  $clog2(FIFO_DEPTH)+1  number of stored entries
//  overflow    out  1   sticky: completed frame dropped because FIFO full
//  parity_err  out  1   sticky: frame with bad odd parity discarded
//  frame_err   out  1   sticky: bad stop bit or watchdog timeout
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, FSM IDLE, filtered clock = 1, watchdog = 0.
//  Input: ps2_clk and ps2_data each pass a 2-FF synchronizer.
//   Filtered clock toggles only after FILTER_LEN consecutive synchronized samples differ from it.
//   fall = filtered clock 1->0; ps2_data (synchronized) is sampled on that cycle.
//  FSM, advancing on fall only:
//   IDLE: data==0 -> DATA, bit_cnt=0; data==1 -> stay (spurious edge ignored, no error).
//   DATA: shift right, new bit into [7] (LSB first); after 8th bit -> PARITY.
//   PARITY: latch p; -> STOP.
//   STOP: ok = (^shift ^ p)==1 && data==1.
//    ok, FIFO not full (or rd in same cycle) -> push.
//    ok, full, no rd -> drop, overflow<=1.
//    parity bad -> drop, parity_err<=1.
//    stop bit 0 -> drop, frame_err<=1 (parity_err wins if both bad).
//    -> IDLE in all cases.
//  Watchdog: counts while FSM != IDLE, cleared on every fall. At TIMEOUT-1: FSM->IDLE, partial frame
//   discarded, frame_err<=1.
//  Latency: pushed byte visible (ready=1, data_out valid) the cycle after the STOP-fall cycle.
//   Raw edge to fall is FILTER_LEN+2 cycles.
//  FIFO: circular, pointers wrap at FIFO_DEPTH. rd with ready=1 pops; data_out shows next entry next cycle.
//   Push + pop same cycle: both happen, count unchanged, also when full (no overflow).
//   rd while empty: no effect, count stays 0.
//  clr_err clears all sticky flags. A flag event in the same cycle as clr_err wins (flag set).
//  rst mid-frame: frame discarded, FIFO emptied, no flag set.
//  The next frame after reset must start with a fresh start bit.
// TESTING  (FILTER_LEN=4, FIFO_DEPTH=4, TIMEOUT=400, ps2_clk period 40 clk, data changed at ps2_clk high midpoint)
//  1 Send 0x1C (bits 0,00111000,p=0,1) -> ready=1, data_out=0x1C, count=1. rd -> ready=0, count=0.
//  2 Send 0x1C with p=1 -> no push, parity_err=1. clr_err -> 0. Then 0xF0 (p=1) -> data_out=0xF0.
//  3 Send 5 frames 0x01..0x05 with no rd -> count=4, overflow=1. Pops return 0x01..0x04.
//    Case with rd on the STOP-fall cycle while full: no overflow, 0x05 stored.
//  4 Send start + 4 data bits, then idle 500 clk -> frame_err=1, FSM IDLE. Next full 0x1C frame received correctly.
//  5 Inject 2-cycle low glitches on ps2_clk while high, mid-frame -> ignored; frame 0x5A received intact.
//  6 Assert rst after 6 bits of a frame -> outputs 0, count=0. Following 0x1C frame -> data_out=0x1C, no flags.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronised and glitch-filtered clock, 11-bit frame checker with watchdog,
// and a show-ahead scancode FIFO with sticky overflow/parity/frame error flags.
module ps2_rx_fifo #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd,
  input  logic                          clr_err,
  output logic [7:0]                    data_out,
  output logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          parity_err,
  output logic                          frame_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

  logic          clk_s1_q, clk_s2_q;
  logic          dat_s1_q, dat_s2_q;
  logic          filt_q;
  logic [FW-1:0] flt_cnt_q;
  logic          fall_s;

  state_e        state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [WW-1:0] wd_q;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  logic          overflow_q, parity_err_q, frame_err_q;
  logic          overflow_d, parity_err_d, frame_err_d;

  logic          stop_fall_s, par_ok_s, frame_ok_s, timeout_s;
  logic          full_s, do_pop_s, do_push_s;
  logic          ovf_evt_s, perr_evt_s, ferr_evt_s;

  // Pad synchronisers and the clock filter: a level change is accepted only after
  // FILTER_LEN consecutive synchronised samples disagree with the filtered level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
      filt_q    <= 1'b1;
      flt_cnt_q <= '0;
    end else begin
      clk_s1_q <= ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data;
      dat_s2_q <= dat_s1_q;
      if (clk_s2_q != filt_q) begin
        if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
          filt_q    <= ~filt_q;
          flt_cnt_q <= '0;
        end else begin
          flt_cnt_q <= flt_cnt_q + FW'(1);
        end
      end else begin
        flt_cnt_q <= '0;
      end
    end
  end

  // The fall cycle is the one in which the filtered clock is about to drop.
  assign fall_s = filt_q & ~clk_s2_q & (flt_cnt_q == FW'(FILTER_LEN - 1));

  // Frame FSM with watchdog; a fall always restarts the watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
      par_q     <= 1'b0;
      wd_q      <= '0;
    end else if (fall_s) begin
      wd_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (!dat_s2_q) begin
            state_q   <= ST_DATA;
            bit_cnt_q <= 3'd0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_DATA: begin
          shift_q   <= {dat_s2_q, shift_q[7:1]};
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_q <= ST_PARITY;
          end else begin
            state_q <= ST_DATA;
          end
        end
        ST_PARITY: begin
          par_q   <= dat_s2_q;
          state_q <= ST_STOP;
        end
        ST_STOP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (wd_q == WW'(TIMEOUT - 1)) begin
        state_q <= ST_IDLE;
        wd_q    <= '0;
      end else begin
        wd_q <= wd_q + WW'(1);
      end
    end else begin
      wd_q <= '0;
    end
  end

  assign stop_fall_s = fall_s && (state_q == ST_STOP);
  assign par_ok_s    = (^shift_q) ^ par_q;
  assign frame_ok_s  = stop_fall_s & par_ok_s & dat_s2_q;
  assign timeout_s   = !fall_s && (state_q != ST_IDLE) && (wd_q == WW'(TIMEOUT - 1));

  assign full_s      = (count_q == CW'(FIFO_DEPTH));
  assign do_pop_s    = rd && (count_q != '0);
  assign do_push_s   = frame_ok_s && (!full_s || do_pop_s);

  assign ovf_evt_s   = frame_ok_s & full_s & ~do_pop_s;
  assign perr_evt_s  = stop_fall_s & ~par_ok_s;
  assign ferr_evt_s  = (stop_fall_s & par_ok_s & ~dat_s2_q) | timeout_s;

  // Sticky flags: a new event outranks a simultaneous clear.
  always_comb begin
    overflow_d   = (overflow_q   & ~clr_err) | ovf_evt_s;
    parity_err_d = (parity_err_q & ~clr_err) | perr_evt_s;
    frame_err_d  = (frame_err_q  & ~clr_err) | ferr_evt_s;
  end

  // Error flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      overflow_q   <= overflow_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Circular scancode buffer; pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= 8'd0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_out   = mem_q[rd_ptr_q];
  assign ready      = (count_q != '0);
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: frames are bit-banged on the pads, expected bytes and flags
// are modelled in the bench and compared when the FIFO is popped.
module tb_ps2_rx_fifo;
  localparam int DEPTH = 4;
  localparam int FLEN  = 4;
  localparam int TO    = 400;

  logic       clk = 1'b0;
  logic       rst, ps2_clk, ps2_data, rd, clr_err;
  logic [7:0] data_out;
  logic       ready;
  logic [2:0] count;
  logic       overflow, parity_err, frame_err;

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  bit exp_ovf, exp_perr, exp_ferr;

  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FLEN), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd(rd), .clr_err(clr_err),
    .data_out(data_out), .ready(ready), .count(count), .overflow(overflow),
    .parity_err(parity_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_count"}, 32'(count), 32'(exp_q.size()));
    check_eq({tag, "_ready"}, 32'(ready), 32'(exp_q.size() != 0));
    check_eq({tag, "_ovf"},   32'(overflow), 32'(exp_ovf));
    check_eq({tag, "_perr"},  32'(parity_err), 32'(exp_perr));
    check_eq({tag, "_ferr"},  32'(frame_err), 32'(exp_ferr));
    if (exp_q.size() != 0) check_eq({tag, "_head"}, 32'(data_out), 32'(exp_q[0]));
  endtask

  task automatic pop_check(input string tag);
    check_eq({tag, "_ready"}, 32'(ready), 32'd1);
    if (exp_q.size() == 0) begin
      check_eq({tag, "_model_empty"}, 32'd0, 32'd1);
    end else begin
      check_eq({tag, "_data"}, 32'(data_out), 32'(exp_q.pop_front()));
    end
    @(negedge clk) rd = 1'b1;
    @(negedge clk) rd = 1'b0;
  endtask

  task automatic do_clr_err();
    @(negedge clk) clr_err = 1'b1;
    @(negedge clk) clr_err = 1'b0;
    exp_ovf = 1'b0; exp_perr = 1'b0; exp_ferr = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    ps2_clk = 1'b1; ps2_data = 1'b1; rd = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_ovf = 1'b0; exp_perr = 1'b0; exp_ferr = 1'b0;
    @(negedge clk);
  endtask

  // Bits: [0]=start, [8:1]=data LSB first, [9]=odd parity, [10]=stop.
  task automatic send_frame(input logic [7:0] d, input int nbits, input bit bad_par,
                            input bit bad_stop, input bit glitch, input bit rd_at_stop);
    logic [10:0] bits;
    bit popped;
    popped = 1'b0;
    bits = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk) ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
      ps2_data = bits[i];
      if (glitch) begin
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
      end else begin
        repeat (10) @(negedge clk);
      end
      ps2_clk = 1'b0;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        rd = 1'b0;
        if (rd_at_stop && i == 10 && !popped && dut.fall_s) begin
          check_eq("stop_pop_data", 32'(data_out), 32'(exp_q.pop_front()));
          rd = 1'b1;
          popped = 1'b1;
        end
      end
      rd = 1'b0;
    end
    @(negedge clk) ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (30) @(negedge clk);
    if (rd_at_stop && !popped) check_eq("stop_fall_seen", 32'd0, 32'd1);
    if (nbits == 11) begin
      if (bad_par)                      exp_perr = 1'b1;
      else if (bad_stop)                exp_ferr = 1'b1;
      else if (exp_q.size() == DEPTH)   exp_ovf  = 1'b1;
      else                              exp_q.push_back(d);
    end
  endtask

  initial begin
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd = 1'b0; clr_err = 1'b0;
    exp_ovf = 1'b0; exp_perr = 1'b0; exp_ferr = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_data_out", 32'(data_out), 32'd0);
    check_status("rst");

    // Basic frame, then pop
    send_frame(8'h1C, 11, 1'b0, 1'b0, 1'b0, 1'b0);
    check_status("f1c");
    pop_check("f1c_pop");
    check_status("f1c_after_pop");

    // rd while empty has no effect
    @(negedge clk) rd = 1'b1;
    @(negedge clk) rd = 1'b0;
    check_status("rd_empty");

    // Bad parity, clear, then a good 0xF0
    send_frame(8'h1C, 11, 1'b1, 1'b0, 1'b0, 1'b0);
    check_status("badpar");
    do_clr_err();
    check_status("badpar_clr");
    send_frame(8'hF0, 11, 1'b0, 1'b0, 1'b0, 1'b0);
    check_status("ff0");
    pop_check("ff0_pop");

    // Overflow with no reads
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 11, 1'b0, 1'b0, 1'b0, 1'b0);
    check_status("ovf");
    for (int k = 0; k < 4; k++) pop_check("ovf_pop");
    check_status("ovf_drained");
    do_clr_err();

    // Full FIFO with a read on the stop-fall cycle: push and pop together
    for (int k = 1; k <= 4; k++) send_frame(8'(k), 11, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h05, 11, 1'b0, 1'b0, 1'b0, 1'b1);
    check_status("full_rw");
    for (int k = 0; k < 4; k++) pop_check("full_rw_pop");
    check_status("full_rw_drained");

    // Partial frame aborted by the watchdog
    send_frame(8'h1C, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (500) @(negedge clk);
    exp_ferr = 1'b1;
    check_status("timeout");
    do_clr_err();
    send_frame(8'h1C, 11, 1'b0, 1'b0, 1'b0, 1'b0);
    check_status("after_to");
    pop_check("after_to_pop");

    // Bad stop bit
    send_frame(8'h33, 11, 1'b0, 1'b1, 1'b0, 1'b0);
    check_status("badstop");
    do_clr_err();

    // Short low glitches on ps2_clk while high
    send_frame(8'h5A, 11, 1'b0, 1'b0, 1'b1, 1'b0);
    check_status("glitch");
    pop_check("glitch_pop");

    // Reset mid-frame with a queued byte
    send_frame(8'hA7, 11, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h1C, 6, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    check_eq("midrst_data_out", 32'(data_out), 32'd0);
    check_status("midrst");
    send_frame(8'h1C, 11, 1'b0, 1'b0, 1'b0, 1'b0);
    check_status("post_rst");
    pop_check("post_rst_pop");
    check_status("end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
